// File: rtl/bufferram_pkg.sv
// Shared types and parameter helpers for the dual-port buffer RAM.
package bufferram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/bufferram_if.sv
// Avalon-MM slave port bundle used for both buffer RAM ports.
interface bufferram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/bufferram_core.sv
// True-dual-port byte-enabled RAM; reads return the pre-write contents.
module bufferram_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 96000,
  parameter int IDX_W  = 17
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [IDX_W-1:0]    a_idx,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic                a_re,
  output logic [DATA_W-1:0]   a_q,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [IDX_W-1:0]    b_idx,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic                b_re,
  output logic [DATA_W-1:0]   b_q
);
  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port A is applied last so it wins any lane left unmasked by the caller.
  always_ff @(posedge clk) begin
    if (a_re) a_q <= mem[a_idx];
    if (b_re) b_q <= mem[b_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (b_we && b_be[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
      if (a_we && a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/bufferram_dualport.sv
// Dual Avalon-MM port buffer RAM with collision rules, write freeze,
// configurable read latency and a hardware clear engine on port A.
module bufferram_dualport
  import bufferram_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              BE_W      = DATA_W / 8,
  parameter int              DEPTH     = 96000,
  parameter int              ADDR_W    = 17,
  parameter int              READ_LAT  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  bufferram_if.slave  a,
  bufferram_if.slave  b,
  input  logic        freeze,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done
);
  localparam int               LAT     = read_lat_ok(READ_LAT) ? READ_LAT : 1;
  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  clr_state_t       state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             wait_reg;
  logic             clr_we;

  logic [ADDR_W-1:0] p_addr  [2];
  logic [BE_W-1:0]   p_be    [2];
  logic [DATA_W-1:0] p_wd    [2];
  logic [DATA_W-1:0] q       [2];
  logic [DATA_W-1:0] rdata   [2];
  logic [IDX_W-1:0]  idx     [2];
  logic [1:0]        p_cs, p_rd, p_wr, acc, in_rng, wr_ok, rd_ok, ram_re, rvalid;

  assign p_addr[0] = a.address;    assign p_addr[1] = b.address;
  assign p_be[0]   = a.byteenable; assign p_be[1]   = b.byteenable;
  assign p_wd[0]   = a.writedata;  assign p_wd[1]   = b.writedata;
  assign p_cs      = {b.chipselect, a.chipselect};
  assign p_rd      = {b.read, a.read};
  assign p_wr      = {b.write, a.write};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              v1_reg, oor_reg, seen_reg;
      logic [DATA_W-1:0] data1;

      assign acc[gi]    = p_cs[gi] & (p_rd[gi] | p_wr[gi]) & ~wait_reg;
      assign in_rng[gi] = ({1'b0, p_addr[gi]} < DEPTH_X);
      assign wr_ok[gi]  = acc[gi] & p_wr[gi] & in_rng[gi] & ~freeze;
      assign rd_ok[gi]  = acc[gi] & p_rd[gi] & ~p_wr[gi];
      assign ram_re[gi] = rd_ok[gi] & in_rng[gi];
      assign idx[gi]    = p_addr[gi][IDX_W-1:0];

      // The RAM output register only loads on in-range reads, so it holds
      // between reads; the flags turn it into 0 after reset or range misses.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v1_reg   <= 1'b0;
          oor_reg  <= 1'b0;
          seen_reg <= 1'b0;
        end else begin
          v1_reg <= rd_ok[gi];
          if (rd_ok[gi]) begin
            oor_reg  <= ~in_rng[gi];
            seen_reg <= 1'b1;
          end
        end
      end

      assign data1 = (seen_reg && !oor_reg) ? q[gi] : '0;

      if (LAT == 2) begin : g_lat2
        logic              v2_reg;
        logic [DATA_W-1:0] out_reg;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            v2_reg  <= 1'b0;
            out_reg <= '0;
          end else begin
            v2_reg <= v1_reg;
            if (v1_reg) out_reg <= data1;
          end
        end
        assign rdata[gi]  = out_reg;
        assign rvalid[gi] = v2_reg;
      end else begin : g_lat1
        assign rdata[gi]  = data1;
        assign rvalid[gi] = v1_reg;
      end
    end
  endgenerate

  assign a.readdata      = rdata[0];
  assign b.readdata      = rdata[1];
  assign a.readdatavalid = rvalid[0];
  assign b.readdatavalid = rvalid[1];
  assign a.waitrequest   = wait_reg;
  assign b.waitrequest   = wait_reg;

  // Port A of the RAM is borrowed by the clear engine; B loses colliding lanes.
  logic              a_we_c;
  logic [IDX_W-1:0]  a_idx_c;
  logic [BE_W-1:0]   a_be_c, b_be_c;
  logic [DATA_W-1:0] a_wd_c;

  assign a_we_c  = clr_we | wr_ok[0];
  assign a_idx_c = clr_we ? cnt_reg : idx[0];
  assign a_be_c  = clr_we ? {BE_W{1'b1}} : p_be[0];
  assign a_wd_c  = clr_we ? CLEAR_VAL : p_wd[0];
  assign b_be_c  = (a_we_c && (a_idx_c == idx[1])) ? (p_be[1] & ~a_be_c) : p_be[1];

  bufferram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk     (clk),
    .a_we    (a_we_c),
    .a_be    (a_be_c),
    .a_idx   (a_idx_c),
    .a_wdata (a_wd_c),
    .a_re    (ram_re[0]),
    .a_q     (q[0]),
    .b_we    (wr_ok[1]),
    .b_be    (b_be_c),
    .b_idx   (idx[1]),
    .b_wdata (p_wd[1]),
    .b_re    (ram_re[1]),
    .b_q     (q[1])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wait_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST) state_next = DONE;
        else                 cnt_next   = cnt_reg + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
      end
      DONE:    clr_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bufferram_dualport.sv
// Directed scoreboard bench for bufferram_dualport (DEPTH 16, READ_LAT 1).
module tb_bufferram_dualport;
  localparam int          DW    = 16;
  localparam int          AW    = 5;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CV    = 16'hC1EA;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic freeze = 1'b0;
  logic clr_start = 1'b0;
  logic clr_busy, clr_done;

  bufferram_if #(.DATA_W(DW), .ADDR_W(AW)) ia ();
  bufferram_if #(.DATA_W(DW), .ADDR_W(AW)) ib ();

  bufferram_dualport #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .READ_LAT  (1),
    .CLEAR_VAL (CV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (ia),
    .b         (ib),
    .freeze    (freeze),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] model [DEPTH];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          done_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output side of the scoreboard: a valid is expected exactly on the due cycle.
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    if (clr_done) done_pulses++;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    chk("a_rvalid", ia.readdatavalid, ev);
    if (ev) begin
      e = qa.pop_front();
      if (ia.readdatavalid) chk("a_rdata", ia.readdata, e.data);
    end
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    chk("b_rvalid", ib.readdatavalid, ev);
    if (ev) begin
      e = qb.pop_front();
      if (ib.readdatavalid) chk("b_rdata", ib.readdata, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.chipselect = 1'b0; ia.read = 1'b0; ia.write = 1'b0;
    ib.chipselect = 1'b0; ib.read = 1'b0; ib.write = 1'b0;
  endtask

  task automatic step();
    tick();
    idle();
  endtask

  task automatic rd(input int p, input int addr);
    exp_t e;
    e.data = (addr < DEPTH) ? model[addr] : 16'h0000;
    e.due  = cyc + 1;
    if (p == 0) begin
      ia.chipselect = 1'b1; ia.read = 1'b1; ia.write = 1'b0; ia.address = AW'(addr);
      qa.push_back(e);
    end else begin
      ib.chipselect = 1'b1; ib.read = 1'b1; ib.write = 1'b0; ib.address = AW'(addr);
      qb.push_back(e);
    end
  endtask

  task automatic wr(input int p, input int addr, input logic [1:0] be, input logic [15:0] d);
    if (!freeze && addr < DEPTH)
      for (int i = 0; i < 2; i++)
        if (be[i]) model[addr][8*i +: 8] = d[8*i +: 8];
    if (p == 0) begin
      ia.chipselect = 1'b1; ia.read = 1'b0; ia.write = 1'b1;
      ia.address = AW'(addr); ia.byteenable = be; ia.writedata = d;
    end else begin
      ib.chipselect = 1'b1; ib.read = 1'b0; ib.write = 1'b1;
      ib.address = AW'(addr); ib.byteenable = be; ib.writedata = d;
    end
  endtask

  initial begin
    int busy_n, wait_n, done_n, done_idx, d0;
    idle();
    ia.address = '0; ia.byteenable = '0; ia.writedata = '0;
    ib.address = '0; ib.byteenable = '0; ib.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_rdata", ia.readdata, 16'h0);
    chk("rst_b_rdata", ib.readdata, 16'h0);
    chk("rst_a_wait", ia.waitrequest, 1'b0);
    chk("rst_b_wait", ib.waitrequest, 1'b0);
    chk("rst_busy", clr_busy, 1'b0);
    chk("rst_done", clr_done, 1'b0);
    reset_n = 1'b1;
    tick();

    // Basic write on A, read back on B one cycle later.
    wr(0, 5, 2'b11, 16'hBEEF); step();
    rd(1, 5); step();
    step();
    chk("b_hold", ib.readdata, 16'hBEEF);

    // Same-word double write: A lanes win, B fills the rest.
    wr(1, 7, 2'b11, 16'h2222); wr(0, 7, 2'b01, 16'h1111); step();
    rd(1, 7); rd(0, 7); step();

    // Mixed-port read during write returns old data, both directions.
    wr(0, 9, 2'b11, 16'h0000); step();
    rd(1, 9); wr(0, 9, 2'b11, 16'h55AA); step();
    rd(1, 9); step();
    rd(0, 9); wr(1, 9, 2'b11, 16'h9696); step();
    rd(0, 9); step();

    // Out-of-range: writes dropped (no aliasing), reads return 0.
    wr(0, 0, 2'b11, 16'h0A0A); step();
    wr(1, 16, 2'b11, 16'hDEAD); step();
    rd(0, 16); rd(1, 31); step();
    rd(0, 0); step();

    // Freeze discards writes but still serves reads.
    wr(0, 3, 2'b11, 16'h3333); wr(1, 4, 2'b11, 16'h0404); step();
    freeze = 1'b1;
    wr(0, 3, 2'b11, 16'h1234); wr(1, 4, 2'b11, 16'h4444); step();
    rd(0, 5); step();
    freeze = 1'b0;
    rd(0, 3); rd(1, 4); step();

    // read+write together is a write with no readdatavalid.
    wr(0, 6, 2'b11, 16'h6666); ia.read = 1'b1; step();
    rd(0, 6); step();

    // Partial byte write, then back-to-back reads and a deselected read.
    wr(1, 5, 2'b10, 16'h12FF); step();
    rd(1, 5); step();
    rd(1, 7); step();
    rd(1, 9); step();
    ia.read = 1'b1; ia.address = 5'd5; step();
    step();

    // Full clear with a read accepted in the clr_start cycle.
    for (int i = 0; i < DEPTH; i++) begin
      wr(0, i, 2'b11, 16'h1100 + 16'(i)); step();
    end
    rd(0, 2); clr_start = 1'b1; step();
    clr_start = 1'b0;
    busy_n = 0; wait_n = 0; done_n = 0; done_idx = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (clr_busy) busy_n++;
      if (ia.waitrequest && ib.waitrequest) wait_n++;
      if (clr_done) begin
        done_n++;
        if (done_idx < 0) done_idx = k;
      end
      clr_start = (k == 3);
      if (k < 15) begin
        ib.chipselect = 1'b1; ib.write = 1'b1; ib.read = 1'b0;
        ib.address = 5'd0; ib.byteenable = 2'b11; ib.writedata = 16'hFFFF;
      end else begin
        idle();
      end
      @(posedge clk);
      #1;
    end
    clr_start = 1'b0;
    idle();
    chk("clr_busy_cycles", busy_n, 16);
    chk("clr_wait_cycles", wait_n, 17);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_done_index", done_idx, 16);
    for (int i = 0; i < DEPTH; i++) model[i] = CV;
    for (int i = 0; i < DEPTH; i++) begin
      rd(1, i); step();
    end
    step(); step();

    // Reset in the middle of a clear aborts it where it stands.
    for (int i = 0; i < DEPTH; i++) begin
      wr(0, i, 2'b11, 16'h2200 + 16'(i)); step();
    end
    clr_start = 1'b1; step();
    clr_start = 1'b0;
    repeat (8) tick();
    d0 = done_pulses;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", clr_busy, 1'b0);
    chk("abort_done", clr_done, 1'b0);
    chk("abort_a_wait", ia.waitrequest, 1'b0);
    chk("abort_b_wait", ib.waitrequest, 1'b0);
    chk("abort_a_rdata", ia.readdata, 16'h0);
    chk("abort_b_rdata", ib.readdata, 16'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) model[i] = CV;
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, i); step();
    end
    repeat (4) step();
    chk("abort_no_done", done_pulses, d0);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bufferram_dualport.md
# bufferram_dualport

Parametrised true-dual-port on-chip frame/sample buffer with two Avalon-MM slave ports (A, B) on a single clock. It is the successor of the fixed 16-bit, 96000-word bidirectional buffer RAM. It adds configurable width, depth and read latency, `readdatavalid`/`waitrequest` handshakes, deterministic same-address collision rules, a write-freeze input and a hardware clear engine. It sits between the Qsys interconnect (port A, CPU side) and a streaming master such as a DMA or video/audio engine (port B).

## Interface
Parameters:
- `DATA_W`, 16: word width; must be a multiple of 8.
- `BE_W`, `DATA_W/8`: byteenable width (derived; do not override).
- `DEPTH`, 96000: number of words.
- `ADDR_W`, 17: address width; requires 2^ADDR_W >= DEPTH.
- `READ_LAT`, 1: read latency, 1 or 2 (2 adds an output register).
- `CLEAR_VAL`, 0: word written by the clear engine.

Ports (x = a, b; one set per port):
- `clk`  in  1: single clock for both ports and all logic.
- `reset_n`  in  1: asynchronous, active-low reset.
- `x_address`  in  ADDR_W: word address.
- `x_chipselect`, `x_read`, `x_write`  in  1: Avalon-MM request qualifiers.
- `x_byteenable`  in  BE_W: per-byte write enable.
- `x_writedata`  in  DATA_W: write data.
- `x_readdata`  out  DATA_W: read data.
- `x_readdatavalid`  out  1: one-cycle pulse qualifying `x_readdata`.
- `x_waitrequest`  out  1: request not accepted this cycle.
- `freeze`  in  1: when high, all writes are accepted and discarded.
- `clr_start`  in  1: start a clear; sampled only in IDLE.
- `clr_busy`  out  1: high while the clear is running.
- `clr_done`  out  1: one-cycle pulse when the clear completes.

## Operation
- A request is accepted when `x_chipselect & (x_read | x_write) & ~x_waitrequest`.
- If `x_read` and `x_write` are both high, the request is treated as a write and no `readdatavalid` is produced.
- Writes update only the lanes enabled by `byteenable`.
- An address >= DEPTH is out of range:
  - writes to it are dropped;
  - reads of it return 0 with a normal `readdatavalid`.
- Same-port read-during-write: the port returns the old data.
- Mixed-port read of a word being written by the other port in the same cycle: returns the old data.
- Both ports writing the same word in the same cycle:
  - port A wins on every lane it enables;
  - port B's lanes not enabled by A are still written.
- `freeze` = 1: writes are accepted (waitrequest low) and discarded; reads are served normally; the clear engine is unaffected.
- Clear FSM:
  - IDLE: waitrequest = 0; `clr_start` = 1 moves to CLEAR and resets the address counter to 0.
  - CLEAR: writes `CLEAR_VAL` to address `cnt`, one word per cycle. `cnt` runs 0..DEPTH-1. At `cnt` = DEPTH-1 the FSM moves to DONE.
  - DONE: `clr_done` = 1 for one cycle, then returns to IDLE.
  - In CLEAR and DONE, both `x_waitrequest` are 1.
  - `clr_start` is ignored outside IDLE.
- Requests accepted in the same cycle `clr_start` is sampled complete normally. Reads already in the pipeline deliver `readdatavalid` during CLEAR.

## Timing
- Read accepted in cycle N: `readdata`/`readdatavalid` appear in cycle N+READ_LAT.
- `readdata` holds its value until the next valid read.
- Throughput is 1 request per cycle per port when not stalled.
- A write is visible to any read accepted in cycle N+1 or later.
- `x_waitrequest` is a registered decode of FSM state, so it does not combinationally depend on request inputs.
- A clear lasts DEPTH+1 cycles from `clr_start` to `clr_done` inclusive of DONE. `clr_busy` is high for exactly DEPTH cycles.
- Reset values: all `readdata` = 0, `readdatavalid` = 0, `waitrequest` = 0, `clr_busy` = 0, `clr_done` = 0, FSM = IDLE, counter = 0.
- Memory contents are not reset.
- `reset_n` low mid-clear aborts immediately: contents stay partially cleared, and no `clr_done` is produced.

## Structure
- Package `bufferram_pkg`: clear FSM state enum (IDLE, CLEAR, DONE) and a `READ_LAT` legality check function.
- Sub-module `bufferram_core`: inferred true-dual-port byte-enabled RAM with old-data read-during-write.
  - Contains no reset and no control logic.
  - The top level provides the collision lane masking, range checks, clear mux on port A, latency pipeline and FSM.

## Test plan
- Write A @5 = 0xBEEF with be = 2'b11; read B @5 (READ_LAT 1): B `readdatavalid` one cycle later with 0xBEEF.
- Same cycle: A writes 0x1111 be = 2'b01 and B writes 0x2222 be = 2'b11, both @7. Read @7 returns 0x2211.
- A writes 0x55AA @9 while B reads @9 (previously 0x0000) in the same cycle: B gets 0x0000; a B read next cycle returns 0x55AA.
- Read @DEPTH returns 0 with `readdatavalid`. `freeze` = 1 plus a write @3 = 0x1234 leaves @3 unchanged.
- DEPTH = 16: `clr_start` after filling memory gives `clr_busy` for 16 cycles, waitrequest high on both ports, one `clr_done` pulse, and every address reads `CLEAR_VAL`.
- `reset_n` asserted at clear cycle 8 (DEPTH = 16): outputs return to reset values asynchronously; words 0..7 = `CLEAR_VAL`, words 8..15 are unchanged.
